// File: rtl/aes256_key_sched.sv
// aes256_key_sched: on-the-fly AES-256 key expansion (FIPS-197).
//
// A 256-bit cipher key is loaded on a start pulse. The 15 round keys (index 0..14) are then
// presented one per valid/ready handshake. Only a sliding 8-word window (w[4r]..w[4r+7]) is
// stored; each transfer shifts in the next four schedule words.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      load key_in and begin the schedule (honoured only when idle)
//   key_in     cipher key, key_in[255:224] = w0 .. key_in[31:0] = w7
//   rk_valid   round_key / rk_idx are valid
//   rk_ready   consumer accepts the current round key
//   round_key  current round key, [127:96] = w[4r] .. [31:0] = w[4r+3]
//   rk_idx     index r of the current round key (0..14)
//   busy       high while the schedule is running
//   done       one-cycle pulse after round key 14 is accepted
//
// Build option:
//   AES_KS_ZEROIZE_EN  when defined, the window (and hence round_key) is cleared on the
//                      transfer of the final key, so no key material remains afterwards.

module aes256_key_sched #(
  parameter int unsigned NR = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] key_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] round_key,
  output logic [3:0]   rk_idx,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0] LastIdx = 4'(NR);

  // AES S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    // ~x == 255 - x selects entry x counted from the MSB end.
    return SboxTable[{~x, 3'b000} +: 8];
  endfunction

  typedef enum logic {StIdle, StRun} state_e;

  state_e         state_q, state_d;
  logic [255:0]   win_q, win_d;
  logic [3:0]     idx_q, idx_d;
  logic           done_q, done_d;

  // Schedule step: t derived from the newest word in the window.
  logic [31:0] p_word, sub_in, sub_out, t_word;
  logic [31:0] n0, n1, n2, n3;
  logic [7:0]  rcon;

  assign p_word = win_q[31:0];
  // Even index: RotWord then SubWord plus Rcon; odd index: SubWord only.
  assign sub_in = idx_q[0] ? p_word : {p_word[23:0], p_word[31:24]};

  for (genvar g = 0; g < 4; g++) begin : gen_subword
    assign sub_out[8*g +: 8] = sbox(sub_in[8*g +: 8]);
  end

  // Rcon[r/2+1] = 2^(r/2) for the even indices 0..12.
  assign rcon   = 8'h01 << idx_q[3:1];
  assign t_word = idx_q[0] ? sub_out : (sub_out ^ {rcon, 24'h000000});

  assign n0 = win_q[255:224] ^ t_word;
  assign n1 = win_q[223:192] ^ n0;
  assign n2 = win_q[191:160] ^ n1;
  assign n3 = win_q[159:128] ^ n2;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          win_d   = key_in;
          idx_d   = 4'd0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (rk_ready) begin
          if (idx_q == LastIdx) begin
            state_d = StIdle;
            done_d  = 1'b1;
`ifdef AES_KS_ZEROIZE_EN
            win_d   = '0;
`else
            win_d   = win_q;
`endif
          end else begin
            win_d = {win_q[127:0], n0, n1, n2, n3};
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      win_q   <= '0;
      idx_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    rk_valid  = (state_q == StRun);
    busy      = (state_q == StRun);
    round_key = win_q[255:128];
    rk_idx    = idx_q;
    done      = done_q;
  end

endmodule
